done_tracker32: RTL and testbench

Tracks completion of up to 32 in-flight entries, such as ROB-tagged stores or outstanding loads, as a registered 32-bit done bitmap. Entries are cleared (busy) on allocation and set (done) on completion. The bitmap drives the downstream `and32` reduction tree. The tree's output returns as `all_done`, which a fence FSM waits on before acknowledging a fence. The block sits directly upstream of `and32` in the dispatch/commit path.

---
 rtl/done_tracker32.sv | 64 ++++++
 tb/tb_done_tracker32.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/done_tracker32.sv
// done_tracker32: 32-entry done bitmap with busy count, sticky protocol error and a fence FSM
// that waits on the external and32 reduction (all_done) before acknowledging.
module done_tracker32 (
  input  logic        clk,
  input  logic        rst_aL,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_idx,
  input  logic        comp_valid,
  input  logic [4:0]  comp_idx,
  input  logic        flush,
  input  logic        fence_req,
  output logic        fence_ready,
  output logic        fence_ack,
  output logic        alloc_stall,
  output logic [31:0] done_vec,
  input  logic        all_done,
  output logic [5:0]  busy_cnt,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t      r_state;
  logic [31:0] r_done;
  logic [5:0]  r_cnt;
  logic        r_err;
  logic        w_alloc, w_comp_set, w_comp_err, w_alloc_clr, w_alloc_err;
  logic [31:0] w_mid, w_next;
  state_t      w_state_next;
  // Completion is applied before allocation, so a same-index pair lands busy.
  always_comb begin
    w_alloc      = alloc_valid & ~alloc_stall;
    w_comp_set   = comp_valid & ~r_done[comp_idx];
    w_comp_err   = comp_valid & r_done[comp_idx];
    w_mid        = r_done | (w_comp_set ? (32'd1 << comp_idx) : 32'd0);
    w_alloc_clr  = w_alloc & w_mid[alloc_idx];
    w_alloc_err  = alloc_valid & (alloc_stall | ~w_mid[alloc_idx]);
    w_next       = w_mid & ~(w_alloc_clr ? (32'd1 << alloc_idx) : 32'd0);
    w_state_next = (r_state == IDLE) ? (fence_req ? WAIT : IDLE) :
                   (r_state == WAIT) ? (all_done ? ACK : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_state <= IDLE;
      r_done  <= '1;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      r_done  <= '1;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_next;
      r_cnt   <= r_cnt + {5'd0, w_alloc_clr} - {5'd0, w_comp_set};
      r_err   <= r_err | w_comp_err | w_alloc_err;
    end
  end
  assign fence_ready = (r_state == IDLE);
  assign fence_ack   = (r_state == ACK);
  assign alloc_stall = (r_state != IDLE);
  assign done_vec    = r_done;
  assign busy_cnt    = r_cnt;
  assign err         = r_err;
endmodule

// File: tb/tb_done_tracker32.sv
// tb_done_tracker32: directed plus random checks of done_tracker32 against an array-based model.
module tb_done_tracker32;
  logic        clk = 1'b0, rst_aL = 1'b0;
  logic        alloc_valid = 1'b0, comp_valid = 1'b0, flush = 1'b0, fence_req = 1'b0;
  logic [4:0]  alloc_idx = '0, comp_idx = '0;
  logic        fence_ready, fence_ack, alloc_stall, err, all_done;
  logic [31:0] done_vec;
  logic [5:0]  busy_cnt;
  int          n_cmp = 0, n_err = 0;
  bit          m_done[32];
  bit          m_err;
  int          m_phase;
  done_tracker32 dut (
    .clk(clk), .rst_aL(rst_aL), .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .comp_valid(comp_valid), .comp_idx(comp_idx), .flush(flush), .fence_req(fence_req),
    .fence_ready(fence_ready), .fence_ack(fence_ack), .alloc_stall(alloc_stall),
    .done_vec(done_vec), .all_done(all_done), .busy_cnt(busy_cnt), .err(err)
  );
  assign all_done = &done_vec;
  always #5 clk = ~clk;
  function automatic logic [31:0] m_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_done[i];
    return v;
  endfunction
  function automatic int m_busy();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_done[i] ? 0 : 1;
    return n;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_done[i] = 1'b1;
    m_err = 1'b0;
    m_phase = 0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".done_vec"}, done_vec, m_vec());
    chk({tag, ".busy_cnt"}, {26'd0, busy_cnt}, m_busy());
    chk({tag, ".err"}, {31'd0, err}, {31'd0, m_err});
    chk({tag, ".fence_ready"}, {31'd0, fence_ready}, {31'd0, m_phase == 0});
    chk({tag, ".fence_ack"}, {31'd0, fence_ack}, {31'd0, m_phase == 2});
    chk({tag, ".alloc_stall"}, {31'd0, alloc_stall}, {31'd0, m_phase != 0});
  endtask
  task automatic cyc(input string tag, input bit av, input int ai, input bit cv, input int ci,
                     input bit fl, input bit fr);
    bit every_done;
    alloc_valid = av; alloc_idx = ai[4:0];
    comp_valid = cv;  comp_idx = ci[4:0];
    flush = fl; fence_req = fr;
    @(posedge clk);
    every_done = (m_busy() == 0);
    if (fl) m_reset();
    else begin
      if (cv) begin
        if (m_done[ci[4:0]]) m_err = 1'b1;
        else m_done[ci[4:0]] = 1'b1;
      end
      if (av) begin
        if (m_phase != 0 || !m_done[ai[4:0]]) m_err = 1'b1;
        else m_done[ai[4:0]] = 1'b0;
      end
      m_phase = (m_phase == 0) ? (fr ? 1 : 0) : (m_phase == 1) ? (every_done ? 2 : 1) : 0;
    end
    #1;
    chk_all(tag);
  endtask
  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    m_reset();
    #12;
    chk_all("reset");
    @(negedge clk) rst_aL = 1'b1;
    idle("idle0");
    idle("idle1");
    cyc("alloc3", 1, 3, 0, 0, 0, 0);
    cyc("alloc17", 1, 17, 0, 0, 0, 0);
    cyc("alloc31", 1, 31, 0, 0, 0, 0);
    chk("allocs.vec", done_vec, 32'h7FFD_FFF7);
    chk("allocs.cnt", {26'd0, busy_cnt}, 32'd3);
    cyc("comp17", 0, 0, 1, 17, 0, 0);
    chk("comp17.vec", done_vec, 32'h7FFF_FFF7);
    chk("comp17.cnt", {26'd0, busy_cnt}, 32'd2);
    cyc("flush0", 0, 0, 0, 0, 1, 0);
    cyc("alloc5", 1, 5, 0, 0, 0, 0);
    cyc("fence.c0", 0, 0, 0, 0, 0, 1);
    chk("fence.stall_c1", {31'd0, alloc_stall}, 32'd1);
    idle("fence.c1");
    idle("fence.c2");
    idle("fence.c3");
    cyc("fence.c4", 0, 0, 1, 5, 0, 0);
    chk("fence.noack_c5", {31'd0, fence_ack}, 32'd0);
    idle("fence.c5");
    chk("fence.ack_c6", {31'd0, fence_ack}, 32'd1);
    idle("fence.c6");
    chk("fence.ready_c7", {31'd0, fence_ready}, 32'd1);
    chk("fence.noack_c7", {31'd0, fence_ack}, 32'd0);
    cyc("alloc9", 1, 9, 0, 0, 0, 0);
    cyc("ac9", 1, 9, 1, 9, 0, 0);
    chk("ac9.bit", {31'd0, done_vec[9]}, 32'd0);
    chk("ac9.cnt", {26'd0, busy_cnt}, 32'd1);
    chk("ac9.err", {31'd0, err}, 32'd0);
    cyc("comp9a", 0, 0, 1, 9, 0, 0);
    chk("comp9a.err", {31'd0, err}, 32'd0);
    cyc("comp9b", 0, 0, 1, 9, 0, 0);
    chk("comp9b.err", {31'd0, err}, 32'd1);
    for (int i = 1; i <= 4; i++) cyc("fl.alloc", 1, i * 6, 0, 0, 0, 0);
    cyc("fl.req", 0, 0, 0, 0, 0, 1);
    idle("fl.wait");
    cyc("fl.flush", 1, 0, 1, 6, 1, 0);
    chk("fl.vec", done_vec, 32'hFFFF_FFFF);
    chk("fl.cnt", {26'd0, busy_cnt}, 32'd0);
    chk("fl.err", {31'd0, err}, 32'd0);
    chk("fl.ready", {31'd0, fence_ready}, 32'd1);
    idle("fl.after0");
    idle("fl.after1");
    cyc("rs.alloc", 1, 7, 0, 0, 0, 0);
    cyc("rs.req", 0, 0, 0, 0, 0, 1);
    idle("rs.wait");
    #2 rst_aL = 1'b0;
    #1 m_reset();
    chk_all("rs.async");
    @(negedge clk) rst_aL = 1'b1;
    for (int i = 0; i < 4; i++) idle("rs.after");
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom % 3) != 0, $urandom % 32, ($urandom % 2) != 0, $urandom % 32,
          ($urandom % 50) == 0, ($urandom % 8) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
